// File: rtl/jtag_dtm_if.sv
// DMI link between the JTAG DTM (master) and the debug module (slave).
`ifndef ABITS
`define ABITS 7
`endif

interface DMIPort #(
    parameter int ABITS = `ABITS
);
    logic [ABITS-1:0] addr;
    logic [31:0]      wdata;
    logic             write_en;
    logic             valid;
    logic [31:0]      rdata;
    logic             ready;

    modport Master (output addr, output wdata, output write_en, output valid,
                    input rdata, input ready);
    modport Slave  (input addr, input wdata, input write_en, input valid,
                    output rdata, output ready);
endinterface

// File: rtl/jtag_dtm.sv
// JTAG debug transport module: oversampled TAP controller, IR/DR chains and a
// single-outstanding DMI master. All JTAG activity is driven by tck edge pulses.
`ifndef ABITS
`define ABITS 7
`endif

module jtag_dtm #(
    parameter int          ABITS  = `ABITS,
    parameter logic [31:0] IDCODE = 32'h2000_0A6F
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   tck,
    input  logic   tms,
    input  logic   tdi,
    output logic   tdo,
    DMIPort.Master dm
);
    localparam int DW = ABITS + 34;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_e;
    typedef enum logic {DMI_IDLE, DMI_REQ} dmi_e;
    typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_e;

    logic [2:0]       tck_sync_q, tck_sync_d;
    logic [1:0]       tms_sync_q, tms_sync_d, tdi_sync_q, tdi_sync_d;
    tap_e             tap_q, tap_d;
    dmi_e             dmi_q, dmi_d;
    logic [4:0]       ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DW-1:0]    dr_sr_q, dr_sr_d, dr_shift;
    logic             tdo_q, tdo_d;
    logic [1:0]       dmistat_q, dmistat_d;
    logic [31:0]      rdata_q, rdata_d, wdata_q, wdata_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic             we_q, we_d;

    logic             tck_rise, tck_fall, tms_s, tdi_s;
    logic             in_tlr, in_cap_dr, in_sh_dr, in_upd_dr, in_cap_ir, in_sh_ir, in_upd_ir;
    logic             launch, abort, busy, busy_upd;
    logic [1:0]       cap_op, upd_op;
    dr_sel_e          dr_sel;

    assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
    assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];
    assign busy     = (dmi_q == DMI_REQ);
    // A completion in the same cycle as an update frees the master first.
    assign busy_upd = busy & ~dm.ready;
    assign upd_op   = dr_sr_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tap_q <= TLR;
        else     tap_q <= tap_d;
    end

    always_comb begin
        tap_d = tap_q;
        if (tck_rise) begin
            case (tap_q)
                TLR:      tap_d = tms_s ? TLR      : RTI;
                RTI:      tap_d = tms_s ? SEL_DR   : RTI;
                SEL_DR:   tap_d = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   tap_d = tms_s ? EX1_DR   : SH_DR;
                SH_DR:    tap_d = tms_s ? EX1_DR   : SH_DR;
                EX1_DR:   tap_d = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: tap_d = tms_s ? EX2_DR   : PAUSE_DR;
                EX2_DR:   tap_d = tms_s ? UPD_DR   : SH_DR;
                UPD_DR:   tap_d = tms_s ? SEL_DR   : RTI;
                SEL_IR:   tap_d = tms_s ? TLR      : CAP_IR;
                CAP_IR:   tap_d = tms_s ? EX1_IR   : SH_IR;
                SH_IR:    tap_d = tms_s ? EX1_IR   : SH_IR;
                EX1_IR:   tap_d = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: tap_d = tms_s ? EX2_IR   : PAUSE_IR;
                EX2_IR:   tap_d = tms_s ? UPD_IR   : SH_IR;
                UPD_IR:   tap_d = tms_s ? SEL_DR   : RTI;
                default:  tap_d = TLR;
            endcase
        end
    end

    always_comb begin
        in_tlr    = (tap_q == TLR);
        in_cap_dr = (tap_q == CAP_DR);
        in_sh_dr  = (tap_q == SH_DR);
        in_upd_dr = (tap_q == UPD_DR);
        in_cap_ir = (tap_q == CAP_IR);
        in_sh_ir  = (tap_q == SH_IR);
        in_upd_ir = (tap_q == UPD_IR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dmi_q <= DMI_IDLE;
        else     dmi_q <= dmi_d;
    end

    always_comb begin
        dmi_d = dmi_q;
        case (dmi_q)
            DMI_IDLE: if (launch) dmi_d = DMI_REQ;
            DMI_REQ: begin
                if (abort)         dmi_d = DMI_IDLE;
                else if (dm.ready) dmi_d = launch ? DMI_REQ : DMI_IDLE;
            end
            default:  dmi_d = DMI_IDLE;
        endcase
    end

    always_comb begin
        dm.valid    = (dmi_q == DMI_REQ);
        dm.addr     = addr_q;
        dm.wdata    = wdata_q;
        dm.write_en = we_q;
        tdo         = tdo_q;
    end

    always_comb begin
        case (ir_q)
            5'h01:   dr_sel = SEL_IDCODE;
            5'h10:   dr_sel = SEL_DTMCS;
            5'h11:   dr_sel = SEL_DMI;
            default: dr_sel = SEL_BYPASS;
        endcase
    end

    always_comb begin
        tck_sync_d = {tck_sync_q[1:0], tck};
        tms_sync_d = {tms_sync_q[0], tms};
        tdi_sync_d = {tdi_sync_q[0], tdi};
        ir_d       = ir_q;
        ir_sr_d    = ir_sr_q;
        dr_sr_d    = dr_sr_q;
        tdo_d      = tdo_q;
        dmistat_d  = dmistat_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        launch     = 1'b0;
        abort      = 1'b0;
        cap_op     = 2'd0;
        dr_shift   = dr_sr_q >> 1;

        if (busy && dm.ready && !we_q) rdata_d = dm.rdata;
        if (in_tlr) ir_d = 5'h01;

        case (dr_sel)
            SEL_BYPASS: dr_shift = {{(DW-1){1'b0}}, tdi_s};
            SEL_DMI:    dr_shift[DW-1] = tdi_s;
            default:    dr_shift[31] = tdi_s;
        endcase

        if (dmistat_q != 2'd0) cap_op = dmistat_q;
        else if (busy)         cap_op = 2'd3;

        if (tck_rise) begin
            if (in_cap_ir) ir_sr_d = 5'b00001;
            if (in_sh_ir)  ir_sr_d = {tdi_s, ir_sr_q[4:1]};
            if (in_upd_ir) ir_d = ir_sr_q;
            if (in_sh_dr)  dr_sr_d = dr_shift;
            if (in_cap_dr) begin
                case (dr_sel)
                    SEL_IDCODE: dr_sr_d = {{(DW-32){1'b0}}, IDCODE};
                    SEL_DTMCS:  dr_sr_d = {{(DW-32){1'b0}}, 14'b0, 2'b00, 1'b0, 3'd1,
                                           dmistat_q, 6'(ABITS), 4'd1};
                    SEL_DMI: begin
                        dr_sr_d = {addr_q, rdata_q, cap_op};
                        if (dmistat_q == 2'd0 && busy) dmistat_d = 2'd3;
                    end
                    default:    dr_sr_d = '0;
                endcase
            end
            if (in_upd_dr && dr_sel == SEL_DTMCS) begin
                if (dr_sr_q[16] || dr_sr_q[17]) dmistat_d = 2'd0;
                abort = dr_sr_q[17];
            end
            if (in_upd_dr && dr_sel == SEL_DMI && dmistat_q == 2'd0) begin
                if (busy_upd) begin
                    dmistat_d = 2'd3;
                end else if (upd_op == 2'd1 || upd_op == 2'd2) begin
                    addr_d = dr_sr_q[DW-1:34];
                    we_d   = (upd_op == 2'd2);
                    if (upd_op == 2'd2) wdata_d = dr_sr_q[33:2];
                    launch = 1'b1;
                end
            end
        end

        if (tck_fall) begin
            if (in_sh_dr)      tdo_d = dr_sr_q[0];
            else if (in_sh_ir) tdo_d = ir_sr_q[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            ir_q       <= 5'h01;
            ir_sr_q    <= 5'h01;
            dr_sr_q    <= '0;
            tdo_q      <= 1'b0;
            dmistat_q  <= 2'd0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            tck_sync_q <= tck_sync_d;
            tms_sync_q <= tms_sync_d;
            tdi_sync_q <= tdi_sync_d;
            ir_q       <= ir_d;
            ir_sr_q    <= ir_sr_d;
            dr_sr_q    <= dr_sr_d;
            tdo_q      <= tdo_d;
            dmistat_q  <= dmistat_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end
endmodule
